// File: rtl/mod_147_5_rx_if.sv
// rtl/mod_147_5_rx_if.sv - symbol-in / MII-out bundle for the 10BASE-T1S PCS receive path
//
// Purpose: groups the PMA symbol strobe and the MII receive signals.
// Signals:
//   rx_sym_valid  one-cycle strobe, rx_sym holds a new 5B symbol
//   rx_sym        received 5B symbol
//   RXD           decoded nibble
//   RX_DV         receive data valid
//   RX_ER         receive error, qualified by RX_DV
//   esd_brs       one-clk pulse on an accepted ESDBRS delimiter
// Modports: master = PMA/MII side, slave = PCS receive block.
interface mod_147_5_rx_if;
  logic       rx_sym_valid;
  logic [4:0] rx_sym;
  logic [3:0] RXD;
  logic       RX_DV;
  logic       RX_ER;
  logic       esd_brs;

  modport master (
    output rx_sym_valid, rx_sym,
    input  RXD, RX_DV, RX_ER, esd_brs
  );

  modport slave (
    input  rx_sym_valid, rx_sym,
    output RXD, RX_DV, RX_ER, esd_brs
  );
endinterface

// File: rtl/mod_147_5_rx.sv
// rtl/mod_147_5_rx.sv - 10BASE-T1S PCS receive: start detect, 4B/5B decode, end-delimiter check
//
// Purpose: hunts SYNC/SYNC/SSD/SSD, emits a regenerated preamble nibble then decoded
// data nibbles on MII, and checks the end delimiter. A 2-entry nibble pipe delays MII
// by two strobes so the last nibble can still be marked bad while RX_DV is high.
// Ports:
//   clk              PCS clock
//   pcs_reset_n      asynchronous active-low reset
//   link_control     1 = DISABLE, synchronously forces IDLE
//   rx_if (slave)    rx_sym_valid/rx_sym in, RXD/RX_DV/RX_ER/esd_brs out
//   mod_147_5_state  current state, for debug
module mod_147_5_rx #(
  parameter int         MAX_DATA_NIB = 4096,
  parameter logic [4:0] SILENCE_SYM  = 5'b11111,
  parameter logic [4:0] SYNC_SYM     = 5'b11000,
  parameter logic [4:0] SSD_SYM      = 5'b10001,
  parameter logic [4:0] ESD_SYM      = 5'b01101,
  parameter logic [4:0] ESDOK_SYM    = 5'b00111,
  parameter logic [4:0] ESDBRS_SYM   = 5'b00110,
  parameter logic [4:0] ESDERR_SYM   = 5'b00100,
  parameter logic [4:0] ESDJAB_SYM   = 5'b11001
) (
  input  logic               clk,
  input  logic               pcs_reset_n,
  input  logic               link_control,
  mod_147_5_rx_if.slave      rx_if,
  output logic [2:0]         mod_147_5_state
);

  localparam int CW = $clog2(MAX_DATA_NIB + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA_NIB);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SYNC_ST      = 3'd1,
    SSD_ST       = 3'd2,
    DATA         = 3'd3,
    ESD_ST       = 3'd4,
    TAIL         = 3'd5,
    WAIT_SILENCE = 3'd6
  } state_t;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [3:0] nib;
  } ent_t;

  localparam ent_t EMPTY = '0;

  state_t        state_q, state_d;
  ent_t          p0_q, p0_d, p1_q, p1_d, mii_q, mii_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          jab_q, jab_d;
  logic          brs_q, brs_d;
  logic [4:0]    dec;

  // Returns {code_valid, nibble}.
  function automatic logic [4:0] decode(input logic [4:0] s);
    case (s)
      5'b11110: return {1'b1, 4'h0};
      5'b01001: return {1'b1, 4'h1};
      5'b10100: return {1'b1, 4'h2};
      5'b10101: return {1'b1, 4'h3};
      5'b01010: return {1'b1, 4'h4};
      5'b01011: return {1'b1, 4'h5};
      5'b01110: return {1'b1, 4'h6};
      5'b01111: return {1'b1, 4'h7};
      5'b10010: return {1'b1, 4'h8};
      5'b10011: return {1'b1, 4'h9};
      5'b10110: return {1'b1, 4'hA};
      5'b10111: return {1'b1, 4'hB};
      5'b11010: return {1'b1, 4'hC};
      5'b11011: return {1'b1, 4'hD};
      5'b11100: return {1'b1, 4'hE};
      5'b11101: return {1'b1, 4'hF};
      default:  return 5'b0_0000;
    endcase
  endfunction

  assign dec = decode(rx_if.rx_sym);

  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    mii_d   = mii_q;
    cnt_d   = cnt_q;
    jab_d   = jab_q;
    brs_d   = 1'b0;
    if (rx_if.rx_sym_valid) begin
      // MII always shows the older pipe entry, captured before the pipe moves.
      mii_d = p1_q;
      case (state_q)
        IDLE: begin
          if (rx_if.rx_sym == SYNC_SYM) state_d = SYNC_ST;
        end
        SYNC_ST: begin
          if (rx_if.rx_sym == SSD_SYM)       state_d = SSD_ST;
          else if (rx_if.rx_sym != SYNC_SYM) state_d = IDLE;
        end
        SSD_ST: begin
          if (rx_if.rx_sym == SSD_SYM) begin
            state_d = DATA;
            p0_d    = '{v: 1'b1, e: 1'b0, nib: 4'h5};
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          p1_d = p0_q;
          if (rx_if.rx_sym == ESD_SYM) begin
            p0_d    = EMPTY;
            state_d = ESD_ST;
          end else if (rx_if.rx_sym == SILENCE_SYM) begin
            p1_d.e  = 1'b1;
            p0_d    = EMPTY;
            state_d = TAIL;
          end else if (cnt_q == CNT_MAX) begin
            // Jabber: this symbol is dropped; the counter never passes CNT_MAX.
            p1_d.e  = 1'b1;
            p0_d    = EMPTY;
            jab_d   = 1'b1;
            state_d = TAIL;
          end else begin
            p0_d  = '{v: 1'b1, e: ~dec[4], nib: dec[4] ? dec[3:0] : 4'h0};
            cnt_d = cnt_q + CW'(1);
          end
        end
        ESD_ST: begin
          mii_d.e = p1_q.e | ((rx_if.rx_sym != ESDOK_SYM) && (rx_if.rx_sym != ESDBRS_SYM));
          p1_d    = EMPTY;
          brs_d   = (rx_if.rx_sym == ESDBRS_SYM);
          state_d = (rx_if.rx_sym == SYNC_SYM) ? SYNC_ST : IDLE;
        end
        TAIL: begin
          p1_d    = EMPTY;
          state_d = jab_q ? WAIT_SILENCE : IDLE;
        end
        WAIT_SILENCE: begin
          if (rx_if.rx_sym == SILENCE_SYM) begin
            state_d = IDLE;
            jab_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge pcs_reset_n) begin
    if (!pcs_reset_n) begin
      state_q <= IDLE;
      p0_q    <= EMPTY;
      p1_q    <= EMPTY;
      mii_q   <= EMPTY;
      cnt_q   <= '0;
      jab_q   <= 1'b0;
      brs_q   <= 1'b0;
    end else if (link_control) begin
      state_q <= IDLE;
      p0_q    <= EMPTY;
      p1_q    <= EMPTY;
      mii_q   <= EMPTY;
      cnt_q   <= '0;
      jab_q   <= 1'b0;
      brs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      mii_q   <= mii_d;
      cnt_q   <= cnt_d;
      jab_q   <= jab_d;
      brs_q   <= brs_d;
    end
  end

  assign rx_if.RX_DV      = mii_q.v;
  assign rx_if.RX_ER      = mii_q.v & mii_q.e;
  assign rx_if.RXD        = mii_q.v ? mii_q.nib : 4'h0;
  assign rx_if.esd_brs    = brs_q;
  assign mod_147_5_state  = state_q;

  // Both ESDERR and ESDJAB simply fall into the "not OK/BRS" error case.
  logic unused_syms;
  assign unused_syms = ^{ESDERR_SYM, ESDJAB_SYM};

endmodule
